hex_display_scanner: RTL and testbench
======================================

Name: hex_display_scanner

Overview:
Time-multiplexed scan controller for a bank of common-anode 7-segment digits. Latches a multi-digit hex value on a load strobe and double-buffers it so no frame tears. Steps one digit per prescaler period. Sits directly upstream of the hex-to-segment decoder: drives the nibble it decodes, plus the digit select, decimal point and blank qualifiers that downstream logic combines with the decoded segments.

Parameters:
DIGITS, 8, number of multiplexed digits (2..16); digit 0 is least significant.
PRESCALE, 50000, clk cycles each digit stays active (>=2).
BLANK_LEADING, 1, 1 = suppress leading zero digits; 0 = show all digits.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
load  in  1  single-cycle strobe; captures value and dp_mask
value  in  4*DIGITS  hex value; nibble i = value[4i+3:4i] for digit i
dp_mask  in  DIGITS  decimal point request per digit
digit_en  out  DIGITS  one-hot active-high digit select, registered
nibble  out  4  hex nibble of active digit, to decoder data input, registered
dp  out  1  decimal point of active digit, registered
blank  out  1  1 = active digit suppressed; downstream forces segments off, registered
frame_done  out  1  one-cycle pulse when the last digit's period ends

Behaviour:
- Reset (rst=1 at clk edge): prescaler=0, index=0, display and pending registers=0, pending_valid=0, digit_en=1 (digit 0 only), nibble=0, dp=0, blank=0, frame_done=0. Reset mid-frame discards any pending load.
- Prescaler counts 0..PRESCALE-1, then wraps to 0. tick=(count==PRESCALE-1).
- Index: increments on tick; after DIGITS-1 it wraps to 0. Each digit is active for exactly PRESCALE cycles.
- frame_done: asserted in the cycle after the tick where index goes DIGITS-1 -> 0, in step with the output update.
- Load: on load=1, {value, dp_mask} go to the pending register and pending_valid is set. A second load before transfer overwrites pending (last one wins).
- Transfer: on the wrap tick (index DIGITS-1 -> 0), if pending_valid=1, pending moves to the display register and pending_valid clears.
- Load coinciding with the wrap tick: the incoming value goes straight to the display register, bypassing pending, and pending_valid ends at 0.
- Display changes only at frame boundaries. Digits 1..DIGITS-1 never show a mix of old and new values within one frame.
- Outputs are registered from the next index and display state. They change exactly one cycle after the tick edge, all together.
- Leading-zero blank (BLANK_LEADING=1): digit i (i>=1) is blanked iff display nibbles i..DIGITS-1 are all 0 and dp_mask bits i..DIGITS-1 are all 0.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - When blank=1, dp=0 and nibble still carries the stored nibble.
- BLANK_LEADING=0: blank is tied 0.
- digit_en always has exactly one bit set, including during and immediately after reset.

Decomposition:
- Shared package (display_pkg): DIGIT_W=4, default DIGITS/PRESCALE constants, and a function lz_mask(value, dp) returning a DIGITS-wide blank vector.
- Sub-module: display_prescaler (free-running modulo-PRESCALE counter with tick output). It is reusable by other display blocks.
- Index, double buffer and output registers stay in the top.

Test Plan (bench uses DIGITS=4, PRESCALE=4):
- Reset then idle 40 cycles -> digit_en sequence 0001,0010,0100,1000 repeating, each held 4 cycles; nibble=0; blank=1 on digits 1-3 and 0 on digit 0; frame_done pulses every 16 cycles.
- load value=16'h00A3, dp_mask=0 mid-frame -> display unchanged until next frame_done; then digit0 nibble=3, digit1 nibble=A, digits 2-3 blank=1.
- load 16'h1234, then load 16'h5678 before the wrap -> next frame shows 8,7,6,5 on digits 0-3; 1234 is never displayed.
- load 16'h0005 with dp_mask=4'b0100 -> digit2 blank=0 with dp=1 and nibble=0; digit3 blank=1; digit1 blank=0 with nibble=0.
- load asserted in exactly the wrap-tick cycle with 16'hBEEF -> the frame starting next cycle shows F,E,E,B; no further update at the following frame.
- rst asserted mid-frame with a load pending -> next cycle digit_en=0001, nibble=0, frame_done=0; the pending value is never shown.

Source files
------------

// File: rtl/hex_display_scanner_pkg.sv
// Shared constants and helpers for the multiplexed hex display blocks.
// lz_mask works on a fixed 16-digit width so any DIGITS up to 16 can reuse it.
package display_pkg;

    localparam int DIGIT_W      = 4;
    localparam int MAX_DIGITS   = 16;
    localparam int FULL_W       = DIGIT_W * MAX_DIGITS;
    localparam int DEF_DIGITS   = 8;
    localparam int DEF_PRESCALE = 50000;

    // Bit i set when digit i (i>=1) is a leading zero: it and every higher digit
    // carry a zero nibble and no decimal point. Digit 0 is never blanked.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [FULL_W-1:0]     value,
        input logic [MAX_DIGITS-1:0] dp,
        input int                    digits
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  seen;
        mask = '0;
        seen = 1'b0;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < digits) begin
                seen    = seen | (|value[DIGIT_W*i +: DIGIT_W]) | dp[i];
                mask[i] = ~seen;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/hex_display_scanner_prescaler.sv
// Free-running modulo-PRESCALE counter; o_tick is high in the last count of each period.
module display_prescaler #(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CNT_W-1:0] r_count;

    assign o_tick = (r_count == CNT_W'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (o_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hex_display_scanner.sv
// Scan controller for common-anode 7-segment digits with a frame-synchronous
// double buffer; outputs feed the hex-to-segment decoder one digit at a time.
module hex_display_scanner
    import display_pkg::*;
#(
    parameter int DIGITS        = DEF_DIGITS,
    parameter int PRESCALE      = DEF_PRESCALE,
    parameter int BLANK_LEADING = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [DIGIT_W*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]         dp_mask,
    output logic [DIGITS-1:0]         digit_en,
    output logic [DIGIT_W-1:0]        nibble,
    output logic                      dp,
    output logic                      blank,
    output logic                      frame_done
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int VAL_W = DIGIT_W * DIGITS;

    logic [IDX_W-1:0]      r_index;
    logic [VAL_W-1:0]      r_disp_val;
    logic [DIGITS-1:0]     r_disp_dp;
    logic [VAL_W-1:0]      r_pend_val;
    logic [DIGITS-1:0]     r_pend_dp;
    logic                  r_pend_valid;

    logic                  w_tick;
    logic                  w_wrap;
    logic [IDX_W-1:0]      w_next_index;
    logic [VAL_W-1:0]      w_next_val;
    logic [DIGITS-1:0]     w_next_dp;
    logic [MAX_DIGITS-1:0] w_lz;
    logic [DIGITS-1:0]     w_blank_vec;
    logic                  w_next_blank;

    display_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .o_tick (w_tick)
    );

    assign w_wrap = w_tick && (r_index == IDX_W'(DIGITS - 1));

    always_comb begin
        w_next_index = r_index;
        if (w_tick) begin
            w_next_index = w_wrap ? '0 : r_index + IDX_W'(1);
        end
    end

    // A load landing on the wrap tick wins over anything still pending.
    always_comb begin
        w_next_val = r_disp_val;
        w_next_dp  = r_disp_dp;
        if (w_wrap) begin
            if (load) begin
                w_next_val = value;
                w_next_dp  = dp_mask;
            end else if (r_pend_valid) begin
                w_next_val = r_pend_val;
                w_next_dp  = r_pend_dp;
            end
        end
    end

    assign w_lz         = lz_mask(FULL_W'(w_next_val), MAX_DIGITS'(w_next_dp), DIGITS);
    assign w_blank_vec  = (BLANK_LEADING != 0) ? w_lz[DIGITS-1:0] : '0;
    assign w_next_blank = w_blank_vec[w_next_index];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_index      <= '0;
            r_disp_val   <= '0;
            r_disp_dp    <= '0;
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
            digit_en     <= DIGITS'(1);
            nibble       <= '0;
            dp           <= 1'b0;
            blank        <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            r_index    <= w_next_index;
            r_disp_val <= w_next_val;
            r_disp_dp  <= w_next_dp;
            if (load && !w_wrap) begin
                r_pend_val   <= value;
                r_pend_dp    <= dp_mask;
                r_pend_valid <= 1'b1;
            end else if (w_wrap) begin
                r_pend_valid <= 1'b0;
            end
            // Outputs track the state being entered so they move with the index.
            digit_en   <= DIGITS'(1) << w_next_index;
            nibble     <= w_next_val[int'(w_next_index)*DIGIT_W +: DIGIT_W];
            dp         <= w_next_dp[w_next_index] & ~w_next_blank;
            blank      <= w_next_blank;
            frame_done <= w_wrap;
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Randomized and directed bench for hex_display_scanner (DIGITS=4, PRESCALE=4)
// against a cycle-count based frame model.
module tb_hex_display_scanner;

    localparam int D     = 4;
    localparam int P     = 4;
    localparam int FRAME = D * P;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [3:0]  digit_en;
    logic [3:0]  nibble;
    logic        dp;
    logic        blank;
    logic        frame_done;

    int passed;
    int total;

    hex_display_scanner #(
        .DIGITS        (D),
        .PRESCALE      (P),
        .BLANK_LEADING (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .dp_mask    (dp_mask),
        .digit_en   (digit_en),
        .nibble     (nibble),
        .dp         (dp),
        .blank      (blank),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: n counts edges since reset; the display takes the newest load
    // seen since the previous frame boundary whenever n hits a multiple of FRAME.
    int          n;
    bit          m_ok;
    logic [15:0] m_disp;
    logic [3:0]  m_dpm;
    logic [15:0] m_pend;
    logic [3:0]  m_pdp;
    bit          m_pv;

    initial begin
        n = 0; m_ok = 0; m_disp = 0; m_dpm = 0; m_pend = 0; m_pdp = 0; m_pv = 0;
        passed = 0; total = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            n = 0; m_disp = 0; m_dpm = 0; m_pv = 0; m_ok = 1;
        end else if (m_ok) begin
            n++;
            if (load) begin
                m_pend = value; m_pdp = dp_mask; m_pv = 1;
            end
            if ((n % FRAME) == 0 && m_pv) begin
                m_disp = m_pend; m_dpm = m_pdp; m_pv = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            int        d;
            bit        e_blank;
            logic [10:0] exp_v;
            logic [10:0] act_v;
            d = (n / P) % D;
            e_blank = (d != 0);
            for (int j = 0; j < D; j++) begin
                if (j >= d && (m_disp[4*j +: 4] != 0 || m_dpm[j])) e_blank = 0;
            end
            exp_v = {4'(1 << d), m_disp[4*d +: 4], m_dpm[d] & ~e_blank, e_blank,
                     (n > 0 && (n % FRAME) == 0)};
            act_v = {digit_en, nibble, dp, blank, frame_done};
            total++;
            if (act_v === exp_v) passed++;
            else $display("FAIL model n=%0d: {en,nib,dp,blank,fd} got %b expected %b", n, act_v, exp_v);
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] m);
        load = 1'b1; value = v; dp_mask = m;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_frame();
        bit seen;
        seen = 0;
        for (int k = 0; k < 3 * FRAME && !seen; k++) begin
            @(negedge clk);
            if (frame_done === 1'b1) seen = 1;
        end
        if (!seen) begin
            total++;
            $display("FAIL frame_timeout: got no frame_done expected pulse within %0d cycles", 3 * FRAME);
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value = '0; dp_mask = '0;
        repeat (2) @(negedge clk);
        chk("reset digit_en", 16'(digit_en), 16'h0001);
        chk("reset frame_done", 16'(frame_done), 16'h0000);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        pulse_load(16'h00A3, 4'b0000);
        chk("A3 not yet shown", 16'(nibble), 16'h0000);
        wait_frame();
        chk("A3 d0 nibble", 16'(nibble), 16'h0003);
        repeat (P) @(negedge clk);
        chk("A3 d1 nibble", 16'(nibble), 16'h000A);
        chk("A3 d1 blank", 16'(blank), 16'h0000);
        repeat (P) @(negedge clk);
        chk("A3 d2 blank", 16'(blank), 16'h0001);

        pulse_load(16'h1234, 4'b0000);
        repeat (2) @(negedge clk);
        pulse_load(16'h5678, 4'b0000);
        wait_frame();
        chk("5678 d0", 16'(nibble), 16'h0008);
        repeat (P) @(negedge clk);
        chk("5678 d1", 16'(nibble), 16'h0007);

        pulse_load(16'h0005, 4'b0100);
        wait_frame();
        chk("0005 d0", 16'(nibble), 16'h0005);
        repeat (P) @(negedge clk);
        chk("0005 d1 blank", 16'(blank), 16'h0000);
        repeat (P) @(negedge clk);
        chk("0005 d2 {dp,blank,nib}", {10'b0, dp, blank, nibble}, 16'h0020);
        repeat (P) @(negedge clk);
        chk("0005 d3 blank", 16'(blank), 16'h0001);

        wait_frame();
        repeat (FRAME - 1) @(negedge clk);
        pulse_load(16'hBEEF, 4'b0000);
        chk("BEEF frame_done", 16'(frame_done), 16'h0001);
        chk("BEEF d0", 16'(nibble), 16'h000F);
        repeat (P) @(negedge clk);
        chk("BEEF d1", 16'(nibble), 16'h000E);
        wait_frame();
        chk("BEEF hold d0", 16'(nibble), 16'h000F);

        pulse_load(16'h9999, 4'hF);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst digit_en", 16'(digit_en), 16'h0001);
        chk("rst nibble", 16'(nibble), 16'h0000);
        chk("rst frame_done", 16'(frame_done), 16'h0000);
        wait_frame();
        chk("rst discard d0", 16'(nibble), 16'h0000);
        repeat (P) @(negedge clk);
        chk("rst discard d1 blank", 16'(blank), 16'h0001);

        for (int c = 0; c < 500; c++) begin
            logic [15:0] v;
            int          k;
            if ($urandom_range(7) == 0) begin
                v = 16'($urandom);
                k = $urandom_range(4);
                v = v & (16'hFFFF >> (4 * k));
                load    = 1'b1;
                value   = v;
                dp_mask = ($urandom_range(2) == 0) ? 4'($urandom) : 4'b0000;
            end else begin
                load = 1'b0;
            end
            rst = ($urandom_range(299) == 0);
            @(negedge clk);
        end
        load = 1'b0; rst = 1'b0;
        repeat (2 * FRAME) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
